// File: rtl/space_invaders_pkg.sv
// Shared definitions for the space-invaders video path: screen geometry,
// colour encoding, and the sprite plotter's state encoding.
package space_invaders_pkg;

  // Visible frame-buffer geometry (320x240).
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  // 3-bit RGB colour.
  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;
  localparam logic [COLOUR_W-1:0] GREEN = 3'b010;

  // Sprite plotter state encoding.
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_PLOT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major scan counter for a W x H sprite bitmap.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : force row = col = 0 (takes priority over en_i)
//   en_i       : advance one pixel (col first, then row)
//   col_o      : current column, 0..W-1
//   row_o      : current row, 0..H-1
//   last_o     : high while the counter points at (H-1, W-1)
module sprite_scan_counter #(
  parameter  int W  = 8,
  parameter  int H  = 8,
  localparam int CW = $clog2(W),
  localparam int RW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          en_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_o
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_end, row_end;

  assign col_end = (col_q == CW'(W - 1));
  assign row_end = (row_q == RW'(H - 1));

  // NOTE: every always_comb output gets a default assignment first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every flop samples the pre-edge value of its inputs regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = col_end && row_end;

endmodule

// File: rtl/sprite_plotter.sv
// Sprite plotter: latches one sprite request, walks its W x H bitmap
// row-major and emits one registered (x, y, colour, plot) pixel per clock
// to the VGA frame-buffer adapter, then pulses finish.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   start        : request strobe, sampled only in IDLE
//   erase        : 1 = write BG_COLOUR, 0 = write colour_in
//   orig_x/y     : sprite top-left corner
//   colour_in    : sprite colour
//   bitmap       : mask, bit r*W+c = row r / column c, bit 0 = top-left
//   x, y, colour : pixel to the adapter
//   plot         : adapter write enable
//   busy         : high from accept through the finish cycle
//   finish       : one-cycle done pulse
module sprite_plotter
  import space_invaders_pkg::*;
#(
  parameter int                   W         = 8,
  parameter int                   H         = 8,
  parameter int                   X_W       = 9,
  parameter int                   Y_W       = 8,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR = BLACK
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                erase,
  input  logic [X_W-1:0]      orig_x,
  input  logic [Y_W-1:0]      orig_y,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic [W*H-1:0]      bitmap,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                finish
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int IW = $clog2(W * H);
  localparam int XS = X_W + 1;
  localparam int YS = Y_W + 1;

  logic [STATE_W-1:0]  state_q, state_d;
  logic                busy_q, busy_d;
  logic                finish_q, finish_d;
  logic                plot_q, plot_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;

  // Latched request fields.
  logic [X_W-1:0]      orig_x_q, orig_x_d;
  logic [Y_W-1:0]      orig_y_q, orig_y_d;
  logic [COLOUR_W-1:0] req_colour_q, req_colour_d;
  logic [W*H-1:0]      bitmap_q, bitmap_d;
  logic                erase_q, erase_d;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          scan_last;

  // The counter idles at (0,0) and only moves while pixels are being emitted.
  sprite_scan_counter #(
    .W (W),
    .H (H)
  ) u_scan (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (state_q == ST_IDLE),
    .en_i    (state_q == ST_PLOT),
    .col_o   (col),
    .row_o   (row),
    .last_o  (scan_last)
  );

  // Screen coordinates carry one extra bit so an origin near the top of the
  // coordinate range overflows into it instead of wrapping onto the screen.
  logic [XS-1:0] sx;
  logic [YS-1:0] sy;
  logic [IW-1:0] pix_idx;
  logic          pix_on;

  assign sx      = {1'b0, orig_x_q} + XS'(col);
  assign sy      = {1'b0, orig_y_q} + YS'(row);
  assign pix_idx = IW'(row) * IW'(W) + IW'(col);
  assign pix_on  = bitmap_q[pix_idx] && (sx < XS'(SCREEN_W)) && (sy < YS'(SCREEN_H));

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    finish_d     = finish_q;
    plot_d       = plot_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    orig_x_d     = orig_x_q;
    orig_y_d     = orig_y_q;
    req_colour_d = req_colour_q;
    bitmap_d     = bitmap_q;
    erase_d      = erase_q;

    case (state_q)
      ST_IDLE: begin
        plot_d   = 1'b0;
        finish_d = 1'b0;
        busy_d   = 1'b0;
        if (start) begin
          orig_x_d     = orig_x;
          orig_y_d     = orig_y;
          req_colour_d = colour_in;
          bitmap_d     = bitmap;
          erase_d      = erase;
          busy_d       = 1'b1;
          state_d      = ST_PLOT;
        end
      end

      ST_PLOT: begin
        // Transparent and off-screen pixels still take their cycle, which
        // keeps the request latency independent of the mask and origin.
        x_d      = sx[X_W-1:0];
        y_d      = sy[Y_W-1:0];
        colour_d = erase_q ? BG_COLOUR : req_colour_q;
        plot_d   = pix_on;
        if (scan_last) state_d = ST_DONE;
      end

      ST_DONE: begin
        // Two cycles in DONE: the first raises finish, the second drops it
        // together with busy and returns to IDLE.
        plot_d = 1'b0;
        if (!finish_q) begin
          finish_d = 1'b1;
        end else begin
          finish_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        plot_d   = 1'b0;
        finish_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // NOTE: the request latches, bitmap included, sit in the reset domain so an
  // aborted request leaves no stale sprite data behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      orig_x_q     <= '0;
      orig_y_q     <= '0;
      req_colour_q <= '0;
      bitmap_q     <= '0;
      erase_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      finish_q     <= finish_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      orig_x_q     <= orig_x_d;
      orig_y_q     <= orig_y_d;
      req_colour_q <= req_colour_d;
      bitmap_q     <= bitmap_d;
      erase_q      <= erase_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter (8x8 sprites, 320x240 screen).
// Expected pixels come from a coordinate-level model: pixel k sits at
// (ox + k%W, oy + k/W), is plotted when its mask bit is set and it lands
// on screen, and x/y show the coordinates modulo 512/256.
module tb_sprite_plotter;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NPIX = W * H;

  typedef struct {
    int          ox;
    int          oy;
    logic [2:0]  col;
    logic [63:0] bmp;
    bit          er;
  } req_t;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    logic       p;
  } pix_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        erase;
  logic [8:0]  orig_x;
  logic [7:0]  orig_y;
  logic [2:0]  colour_in;
  logic [63:0] bitmap;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        finish;

  int checks = 0;
  int errors = 0;

  // Captured outputs of one request.
  logic [8:0] obs_x [NPIX];
  logic [7:0] obs_y [NPIX];
  logic [2:0] obs_c [NPIX];
  logic       obs_p [NPIX];
  logic       obs_b [NPIX];
  logic       obs_f [NPIX];
  logic       a_busy, a_plot, a_fin;       // cycle after accept
  logic       f65, b65, p65;               // cycle after edge E0+W*H+1
  logic       f66, b66;                    // cycle after edge E0+W*H+2

  sprite_plotter #(
    .W (W),
    .H (H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .erase     (erase),
    .orig_x    (orig_x),
    .orig_y    (orig_y),
    .colour_in (colour_in),
    .bitmap    (bitmap),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .finish    (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pix_t model(req_t r, int k);
    pix_t m;
    int sx, sy;
    sx  = r.ox + (k % W);
    sy  = r.oy + (k / W);
    m.x = 9'(sx % 512);
    m.y = 8'(sy % 256);
    m.c = r.er ? 3'b000 : r.col;
    m.p = r.bmp[k] && (sx < 320) && (sy < 240);
    return m;
  endfunction

  function automatic int expected_plots(req_t r);
    int n = 0;
    for (int k = 0; k < NPIX; k++) n += int'(model(r, k).p);
    return n;
  endfunction

  // Drives one request (or relies on start already being high) and records
  // every output cycle. With intrude set, foreign starts are issued mid-run
  // and the follow-up request nxt is presented and held through finish.
  task automatic play_sprite(input req_t r, input req_t nxt, input bit drive, input bit intrude);
    if (drive) begin
      orig_x    = 9'(r.ox);
      orig_y    = 8'(r.oy);
      colour_in = r.col;
      bitmap    = r.bmp;
      erase     = r.er;
      start     = 1'b1;
    end
    @(posedge clk); #1;
    a_busy = busy; a_plot = plot; a_fin = finish;
    start  = 1'b0;
    for (int k = 0; k < NPIX; k++) begin
      @(posedge clk); #1;
      obs_x[k] = x; obs_y[k] = y; obs_c[k] = colour;
      obs_p[k] = plot; obs_b[k] = busy; obs_f[k] = finish;
      if (intrude) begin
        if (k == 4 || k == 39) begin
          orig_x = 9'd200; orig_y = 8'd100; colour_in = 3'b111;
          bitmap = 64'h0F0F_0F0F_0F0F_0F0F; erase = 1'b1; start = 1'b1;
        end else if (k == 5 || k == 40) begin
          start = 1'b0;
        end else if (k == 60) begin
          orig_x = 9'(nxt.ox); orig_y = 8'(nxt.oy); colour_in = nxt.col;
          bitmap = nxt.bmp; erase = nxt.er; start = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    f65 = finish; b65 = busy; p65 = plot;
    @(posedge clk); #1;
    f66 = finish; b66 = busy;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; erase = 1'b0;
    orig_x = '0; orig_y = '0; colour_in = '0; bitmap = '0;
    #3;
    checks++;
    if ({x, y, colour, plot, busy, finish} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%b plot=%b busy=%b fin=%b, want all 0",
               x, y, colour, plot, busy, finish);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({plot, busy, finish} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got plot=%b busy=%b fin=%b, want 000", plot, busy, finish);
    end
  endtask

  task automatic test_full_draw;
    req_t r = '{10, 20, 3'b010, {64{1'b1}}, 1'b0};
    int   n = 0;
    play_sprite(r, r, 1'b1, 1'b0);
    for (int k = 0; k < NPIX; k++) begin
      pix_t e = model(r, k);
      n += int'(obs_p[k] === 1'b1);
      checks++;
      if ({obs_p[k], obs_x[k], obs_y[k], obs_c[k], obs_b[k], obs_f[k]} !== {e.p, e.x, e.y, e.c, 2'b10}) begin
        errors++;
        $display("FAIL full_draw px%0d: got p=%b x=%0d y=%0d c=%b busy=%b fin=%b want p=%b x=%0d y=%0d c=%b busy=1 fin=0",
                 k, obs_p[k], obs_x[k], obs_y[k], obs_c[k], obs_b[k], obs_f[k], e.p, e.x, e.y, e.c);
      end
    end
    checks++;
    if (n != 64) begin errors++; $display("FAIL full_draw plot_count: got %0d want 64", n); end
    checks++;
    if ({a_busy, a_plot, a_fin} !== 3'b100) begin
      errors++; $display("FAIL full_draw accept: got busy/plot/fin=%b%b%b want 100", a_busy, a_plot, a_fin);
    end
    checks++;
    if ({f65, b65, p65, f66, b66} !== 5'b11000) begin
      errors++; $display("FAIL full_draw finish: got fin/busy/plot=%b%b%b then fin/busy=%b%b want 110 then 00",
                         f65, b65, p65, f66, b66);
    end
  endtask

  task automatic test_masked_erase;
    req_t r = '{100, 50, 3'b111, 64'h8000_0000_0000_0001, 1'b1};
    int   n = 0;
    play_sprite(r, r, 1'b1, 1'b0);
    for (int k = 0; k < NPIX; k++) begin
      pix_t e = model(r, k);
      n += int'(obs_p[k] === 1'b1);
      checks++;
      if ({obs_p[k], obs_x[k], obs_y[k], obs_c[k]} !== {e.p, e.x, e.y, e.c}) begin
        errors++;
        $display("FAIL masked_erase px%0d: got p=%b x=%0d y=%0d c=%b want p=%b x=%0d y=%0d c=%b",
                 k, obs_p[k], obs_x[k], obs_y[k], obs_c[k], e.p, e.x, e.y, e.c);
      end
    end
    checks++;
    if (n != 2 || obs_p[0] !== 1'b1 || obs_p[63] !== 1'b1) begin
      errors++; $display("FAIL masked_erase plots: got %0d (p0=%b p63=%b) want 2 at px0/px63", n, obs_p[0], obs_p[63]);
    end
    checks++;
    if ({a_busy, f65, b65, p65, f66, b66} !== 6'b111000) begin
      errors++; $display("FAIL masked_erase timing: got busy0=%b fin/busy/plot=%b%b%b fin/busy=%b%b want 1 110 00",
                         a_busy, f65, b65, p65, f66, b66);
    end
  endtask

  task automatic test_clip;
    req_t r = '{316, 236, 3'b111, {64{1'b1}}, 1'b0};
    int   n = 0;
    play_sprite(r, r, 1'b1, 1'b0);
    for (int k = 0; k < NPIX; k++) begin
      pix_t e = model(r, k);
      n += int'(obs_p[k] === 1'b1);
      checks++;
      if ({obs_p[k], obs_x[k], obs_y[k]} !== {e.p, e.x, e.y}) begin
        errors++;
        $display("FAIL clip px%0d: got p=%b x=%0d y=%0d want p=%b x=%0d y=%0d",
                 k, obs_p[k], obs_x[k], obs_y[k], e.p, e.x, e.y);
      end
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL clip plot_count: got %0d want 16", n); end
    checks++;
    if ({f65, b65, f66, b66} !== 4'b1100) begin
      errors++; $display("FAIL clip finish: got fin/busy=%b%b then %b%b want 11 then 00", f65, b65, f66, b66);
    end
  endtask

  task automatic test_wrap;
    req_t r = '{510, 254, 3'b101, {64{1'b1}}, 1'b0};
    int   n = 0;
    play_sprite(r, r, 1'b1, 1'b0);
    for (int k = 0; k < NPIX; k++) begin
      pix_t e = model(r, k);
      n += int'(obs_p[k] !== 1'b0);
      checks++;
      if ({obs_p[k], obs_x[k], obs_y[k]} !== {e.p, e.x, e.y}) begin
        errors++;
        $display("FAIL wrap px%0d: got p=%b x=%0d y=%0d want p=%b x=%0d y=%0d",
                 k, obs_p[k], obs_x[k], obs_y[k], e.p, e.x, e.y);
      end
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL wrap plot_count: got %0d want 0", n); end
    checks++;
    if ({f65, f66, b66} !== 3'b100) begin
      errors++; $display("FAIL wrap finish: got fin65=%b fin66=%b busy66=%b want 1 0 0", f65, f66, b66);
    end
  endtask

  task automatic test_busy_reject;
    req_t r1 = '{10, 20, 3'b010, {64{1'b1}}, 1'b0};
    req_t r2 = '{40, 60, 3'b110, 64'hA5A5_5A5A_F00F_0FF0, 1'b0};
    req_t rr[2];
    rr[0] = r1; rr[1] = r2;
    for (int j = 0; j < 2; j++) begin
      int n = 0;
      play_sprite(rr[j], r2, (j == 0), (j == 0));
      for (int k = 0; k < NPIX; k++) begin
        pix_t e = model(rr[j], k);
        n += int'(obs_p[k] === 1'b1);
        checks++;
        if ({obs_p[k], obs_x[k], obs_y[k], obs_c[k], obs_b[k], obs_f[k]} !== {e.p, e.x, e.y, e.c, 2'b10}) begin
          errors++;
          $display("FAIL busy_reject req%0d px%0d: got p=%b x=%0d y=%0d c=%b busy=%b fin=%b want p=%b x=%0d y=%0d c=%b busy=1 fin=0",
                   j, k, obs_p[k], obs_x[k], obs_y[k], obs_c[k], obs_b[k], obs_f[k], e.p, e.x, e.y, e.c);
        end
      end
      checks++;
      if (n != expected_plots(rr[j])) begin
        errors++; $display("FAIL busy_reject req%0d plot_count: got %0d want %0d", j, n, expected_plots(rr[j]));
      end
      checks++;
      if ({a_busy, a_plot, f65, b65, f66, b66} !== 6'b101100) begin
        errors++; $display("FAIL busy_reject req%0d timing: got busy0=%b plot0=%b fin/busy=%b%b then %b%b want 1 0 11 00",
                           j, a_busy, a_plot, f65, b65, f66, b66);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit bad = 1'b0;
    orig_x = 9'd10; orig_y = 8'd20; colour_in = 3'b010;
    bitmap = {64{1'b1}}; erase = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (31) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({x, y, colour, plot, busy, finish} !== 23'd0) begin
      errors++;
      $display("FAIL reset_mid abort: got x=%0d y=%0d c=%b plot=%b busy=%b fin=%b want all 0",
               x, y, colour, plot, busy, finish);
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (finish !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL reset_mid idle: got activity after abort, want IDLE with no finish"); end
  endtask

  task automatic test_random;
    for (int j = 0; j < 8; j++) begin
      req_t r;
      int   n = 0;
      r.ox  = (j < 4) ? int'($urandom_range(0, 330)) : int'($urandom_range(0, 511));
      r.oy  = (j < 4) ? int'($urandom_range(0, 250)) : int'($urandom_range(0, 255));
      r.col = 3'($urandom_range(0, 7));
      r.bmp = {$urandom, $urandom};
      r.er  = 1'($urandom_range(0, 1));
      play_sprite(r, r, 1'b1, 1'b0);
      for (int k = 0; k < NPIX; k++) begin
        pix_t e = model(r, k);
        n += int'(obs_p[k] === 1'b1);
        checks++;
        if ({obs_p[k], obs_x[k], obs_y[k], obs_c[k], obs_b[k], obs_f[k]} !== {e.p, e.x, e.y, e.c, 2'b10}) begin
          errors++;
          $display("FAIL random%0d px%0d: got p=%b x=%0d y=%0d c=%b busy=%b fin=%b want p=%b x=%0d y=%0d c=%b busy=1 fin=0",
                   j, k, obs_p[k], obs_x[k], obs_y[k], obs_c[k], obs_b[k], obs_f[k], e.p, e.x, e.y, e.c);
        end
      end
      checks++;
      if (n != expected_plots(r)) begin
        errors++; $display("FAIL random%0d plot_count: got %0d want %0d", j, n, expected_plots(r));
      end
      checks++;
      if ({a_busy, f65, b65, p65, f66, b66} !== 6'b111000) begin
        errors++; $display("FAIL random%0d timing: got busy0=%b fin/busy/plot=%b%b%b fin/busy=%b%b want 1 110 00",
                           j, a_busy, f65, b65, p65, f66, b66);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_draw();
    test_masked_erase();
    test_clip();
    test_wrap();
    test_busy_reject();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
